// File: rtl/nn_pkg.sv
// Shared types and arithmetic helpers for the dense layer datapath.
// Arithmetic matches the original per-neuron nodes bit for bit.
package nn_pkg;

    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        EMIT,
        DONE
    } state_t;

    // Signed 8x8 product truncated to its low byte, added with 8-bit wrap.
    function automatic logic [DW-1:0] mac8(
        input logic [DW-1:0] acc,
        input logic [DW-1:0] a,
        input logic [DW-1:0] w
    );
        return acc + DW'($signed(a) * $signed(w));
    endfunction

    // Negative sums (bit7 set) clamp to zero.
    function automatic logic [DW-1:0] relu8(input logic [DW-1:0] x);
        return x[DW-1] ? '0 : x;
    endfunction

endpackage

// File: rtl/dense_layer_sched_if.sv
// Memory read ports and result stream of the dense layer scheduler.
// master = scheduler side, slave = memories plus downstream buffer.
interface dense_layer_sched_if #(
    parameter int A_W = 4,
    parameter int W_W = 8,
    parameter int O_W = 4
);
    import nn_pkg::*;

    logic [A_W-1:0] act_addr;
    logic [DW-1:0]  act_data;
    logic [W_W-1:0] w_addr;
    logic [DW-1:0]  w_data;
    logic [O_W-1:0] b_addr;
    logic [DW-1:0]  b_data;
    logic           out_valid;
    logic           out_ready;
    logic [O_W-1:0] out_idx;
    logic [DW-1:0]  out_data;

    modport master (
        output act_addr, w_addr, b_addr,
        output out_valid, out_idx, out_data,
        input  act_data, w_data, b_data,
        input  out_ready
    );

    modport slave (
        input  act_addr, w_addr, b_addr,
        input  out_valid, out_idx, out_data,
        output act_data, w_data, b_data,
        output out_ready
    );

endinterface

// File: rtl/dense_mac8.sv
// Shared 8-bit multiply-accumulate with bias add and ReLU.
// o_relu already includes the product presented this cycle when i_en=1.
module dense_mac8
    import nn_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [DW-1:0] i_act,
    input  logic [DW-1:0] i_w,
    input  logic [DW-1:0] i_bias,
    output logic [DW-1:0] o_relu
);

    logic [DW-1:0] r_acc;
    logic [DW-1:0] w_acc_nxt;
    logic [DW-1:0] w_sum;

    // Next accumulator value: add the truncated product when enabled.
    always_comb begin
        w_acc_nxt = r_acc;
        if (i_en) begin
            w_acc_nxt = mac8(r_acc, i_act, i_w);
        end
    end

    // Bias add wraps at 8 bits before ReLU.
    always_comb begin
        w_sum  = w_acc_nxt + i_bias;
        o_relu = relu8(w_sum);
    end

    // Accumulator register, cleared at the start of every neuron.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_nxt;
        end
    end

endmodule

// File: rtl/dense_layer_sched.sv
// Time-multiplexed scheduler for one fully-connected layer.
// Walks neurons in order, one shared MAC, results on a valid/ready stream.
module dense_layer_sched
    import nn_pkg::*;
#(
    parameter int N_IN  = 10,
    parameter int N_OUT = 16,
    parameter int A_W   = 4,
    parameter int W_W   = 8,
    parameter int O_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic busy,
    output logic done,
    dense_layer_sched_if.master bus
);

    // Counter value of the last MAC cycle and of the last address cycle.
    localparam logic [A_W-1:0] C_LAST  = A_W'(N_IN);
    localparam logic [A_W-1:0] C_ALAST = A_W'(N_IN - 1);
    localparam logic [O_W-1:0] C_NLAST = O_W'(N_OUT - 1);

    state_t         r_state;
    logic           r_busy;
    logic           r_done;
    logic           r_valid;
    logic [O_W-1:0] r_idx;
    logic [DW-1:0]  r_data;
    logic [A_W-1:0] r_act_addr;
    logic [W_W-1:0] r_w_addr;
    logic [O_W-1:0] r_neuron;
    logic [A_W-1:0] r_cnt;

    logic           w_clr;
    logic           w_en;
    logic [DW-1:0]  w_relu;

    // Accumulator control: clear on each neuron start, add from MAC cycle 1.
    always_comb begin
        w_clr = ((r_state == IDLE) && start)
             || ((r_state == EMIT) && bus.out_ready);
        w_en  = (r_state == MAC) && (r_cnt != '0);
    end

    dense_mac8 u_mac (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_act  (bus.act_data),
        .i_w    (bus.w_data),
        .i_bias (bus.b_data),
        .o_relu (w_relu)
    );

    // Scheduler FSM with registered outputs and address counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_data     <= '0;
            r_act_addr <= '0;
            r_w_addr   <= '0;
            r_neuron   <= '0;
            r_cnt      <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= MAC;
                        r_busy     <= 1'b1;
                        r_neuron   <= '0;
                        r_cnt      <= '0;
                        r_act_addr <= '0;
                        r_w_addr   <= '0;
                    end
                end
                MAC: begin
                    r_cnt <= r_cnt + A_W'(1);
                    if (r_cnt < C_ALAST) begin
                        r_act_addr <= r_act_addr + A_W'(1);
                        r_w_addr   <= r_w_addr + W_W'(1);
                    end
                    if (r_cnt == C_LAST) begin
                        r_state <= EMIT;
                        r_valid <= 1'b1;
                        r_idx   <= r_neuron;
                        r_data  <= w_relu;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        if (r_neuron == C_NLAST) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= MAC;
                            r_neuron   <= r_neuron + O_W'(1);
                            r_cnt      <= '0;
                            r_act_addr <= '0;
                            // weights are laid out neuron-major, so the
                            // next neuron starts right after the last one
                            r_w_addr   <= r_w_addr + W_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign bus.act_addr  = r_act_addr;
    assign bus.w_addr    = r_w_addr;
    assign bus.b_addr    = r_neuron;
    assign bus.out_valid = r_valid;
    assign bus.out_idx   = r_idx;
    assign bus.out_data  = r_data;

endmodule

// File: tb/tb_dense_layer_sched.sv
// Directed bench for dense_layer_sched with synchronous-read memories.
// Cycle numbers are relative to the cycle in which start is held high.
module tb_dense_layer_sched;
    import nn_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    dense_layer_sched_if bus();

    always #5 clk = ~clk;

    dense_layer_sched dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    logic [7:0] act_mem [10];
    logic [7:0] w_mem   [160];
    logic [7:0] b_mem   [16];

    // Memories return data one cycle after the address.
    always @(posedge clk) begin
        bus.act_data <= act_mem[bus.act_addr];
        bus.w_data   <= w_mem[bus.w_addr];
        bus.b_data   <= b_mem[bus.b_addr];
    end

    int cyc      = 0;
    int t0       = 0;
    int done_cnt = 0;
    int done_rel = -1;
    int hs_idx[$];
    int hs_data[$];
    int hs_rel[$];
    int tests    = 0;
    int fails    = 0;
    int n0;

    int exp_a [16] = '{20, 0, 0, 127, 44, 55, 66, 77,
                       88, 99, 110, 121, 0, 0, 0, 0};
    int exp_b [16] = '{7, 8, 9, 10, 11, 12, 13, 14,
                       15, 16, 17, 18, 19, 20, 21, 0};

    always @(posedge clk) cyc <= cyc + 1;

    // Log handshakes and done pulses mid-cycle.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            hs_idx.push_back(int'(bus.out_idx));
            hs_data.push_back(int'(bus.out_data));
            hs_rel.push_back(cyc - t0);
        end
        if (done) begin
            done_cnt++;
            done_rel = cyc - t0;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic to_neg(input int r);
        while (cyc - t0 < r) @(negedge clk);
    endtask

    task automatic kick();
        @(posedge clk); #1;
        start = 1'b1;
        t0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_start_at(input int r);
        to_neg(r - 1);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic clr_log();
        hs_idx.delete();
        hs_data.delete();
        hs_rel.delete();
        done_rel = -1;
    endtask

    task automatic wait_done(input string tag, input int base);
        int k = 0;
        while (done_cnt == base && k < 600) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, int'(done_cnt > base), 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_once"}, done_cnt - base, 1);
    endtask

    task automatic check_pass(input string tag, input int exp [16],
                              input int bp_k, input int bp_d);
        check({tag, "_count"}, hs_idx.size(), 16);
        if (hs_idx.size() == 16) begin
            for (int k = 0; k < 16; k++) begin
                check($sformatf("%s_idx%0d", tag, k), hs_idx[k], k);
                check($sformatf("%s_data%0d", tag, k), hs_data[k], exp[k]);
                check($sformatf("%s_cyc%0d", tag, k), hs_rel[k],
                      12 + 12 * k + ((k >= bp_k) ? bp_d : 0));
            end
        end
        check({tag, "_done_cyc"}, done_rel, 193 + bp_d);
    endtask

    task automatic fill_a();
        for (int i = 0; i < 10; i++) act_mem[i] = 8'd1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 10; i++) begin
                case (k)
                    0:       w_mem[k * 10 + i] = 8'd2;
                    1:       w_mem[k * 10 + i] = 8'hFD;
                    2, 3:    w_mem[k * 10 + i] = 8'd12;
                    default: w_mem[k * 10 + i] = 8'(k);
                endcase
            end
            case (k)
                0:       b_mem[k] = 8'd0;
                1:       b_mem[k] = 8'd5;
                2:       b_mem[k] = 8'd8;
                3:       b_mem[k] = 8'd7;
                default: b_mem[k] = 8'(k);
            endcase
        end
    endtask

    task automatic fill_b();
        for (int i = 0; i < 10; i++) act_mem[i] = 8'd16;
        for (int j = 0; j < 160; j++) w_mem[j] = 8'd16;
        for (int k = 0; k < 15; k++) b_mem[k] = 8'(7 + k);
        b_mem[15] = 8'hFF;
    endtask

    initial begin
        bus.out_ready = 1'b1;
        fill_a();

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_act_addr", int'(bus.act_addr), 0);
        check("rst_w_addr", int'(bus.w_addr), 0);
        check("rst_b_addr", int'(bus.b_addr), 0);
        check("rst_out_idx", int'(bus.out_idx), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", int'(busy), 0);

        // Nominal pass with address and status probes.
        clr_log();
        n0 = done_cnt;
        kick();
        check("a_busy_c1", int'(busy), 1);
        check("a_act_c1", int'(bus.act_addr), 0);
        check("a_w_c1", int'(bus.w_addr), 0);
        to_neg(5);
        check("a_act_c5", int'(bus.act_addr), 4);
        check("a_w_c5", int'(bus.w_addr), 4);
        to_neg(11);
        check("a_act_c11", int'(bus.act_addr), 9);
        check("a_valid_c11", int'(bus.out_valid), 0);
        to_neg(16);
        check("a_act_c16", int'(bus.act_addr), 3);
        check("a_w_c16", int'(bus.w_addr), 13);
        check("a_b_c16", int'(bus.b_addr), 1);
        to_neg(192);
        check("a_busy_c192", int'(busy), 1);
        check("a_valid_c192", int'(bus.out_valid), 1);
        to_neg(193);
        check("a_done_c193", int'(done), 1);
        check("a_busy_c193", int'(busy), 0);
        wait_done("a", n0);
        check_pass("a", exp_a, 16, 0);

        // Truncation: every product's low byte is zero, output = bias.
        fill_b();
        clr_log();
        n0 = done_cnt;
        kick();
        wait_done("b", n0);
        check_pass("b", exp_b, 16, 0);

        // Backpressure on neuron 3 for five cycles.
        fill_a();
        clr_log();
        n0 = done_cnt;
        kick();
        to_neg(47);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int r = 48; r <= 52; r++) begin
            to_neg(r);
            check($sformatf("c_valid_c%0d", r), int'(bus.out_valid), 1);
            check($sformatf("c_idx_c%0d", r), int'(bus.out_idx), 3);
            check($sformatf("c_data_c%0d", r), int'(bus.out_data), 127);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        to_neg(55);
        check("c_act_c55", int'(bus.act_addr), 1);
        check("c_b_c55", int'(bus.b_addr), 4);
        wait_done("c", n0);
        check_pass("c", exp_a, 3, 5);

        // Reset in the middle of MAC aborts the pass silently.
        clr_log();
        n0 = done_cnt;
        kick();
        to_neg(5);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("d_busy_c7", int'(busy), 0);
        check("d_valid_c7", int'(bus.out_valid), 0);
        check("d_act_c7", int'(bus.act_addr), 0);
        repeat (250) @(negedge clk);
        check("d_no_done", done_cnt - n0, 0);
        check("d_no_out", hs_idx.size(), 0);
        n0 = done_cnt;
        kick();
        wait_done("d2", n0);
        check_pass("d2", exp_a, 16, 0);

        // start pulses while busy are ignored.
        clr_log();
        n0 = done_cnt;
        kick();
        pulse_start_at(3);
        pulse_start_at(100);
        wait_done("e", n0);
        check_pass("e", exp_a, 16, 0);
        check("e_idle_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
